// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
//  Module   : rom_loader
//  Purpose  : Write-side front end for the 128 KB game ROM in external async
//             SRAM. Accepts 32-bit words from the bridge download path and
//             emits four big-endian byte writes per word, each with setup,
//             write-strobe and hold phases. Reports when the download drains.
//  Revision : 1.0 - initial release
// ============================================================================
module rom_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          WE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_valid,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data,
   output logic        wr_ready,
   input  logic        dl_done,
   output logic        rom_wr_en,
   output logic [14:0] rom_addr,
   output logic [1:0]  rom_bank,
   output logic [7:0]  rom_din,
   output logic        load_busy,
   output logic        rom_ready,
   output logic        overflow,
   output logic [17:0] bytes_written
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_STROBE = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   localparam logic [3:0]  STROBE_LAST = 4'(WE_CYCLES - 1);
   localparam logic [31:0] WINDOW      = 32'h0002_0000;
   localparam logic [17:0] BYTES_MAX   = 18'd131072;

   state_t      state;
   state_t      next_state;
   logic        xfer;

   // one-word holding slot between the bridge and the byte sequencer
   logic        pend_valid;
   logic [31:0] pend_word;
   logic [14:0] pend_off;

   // word currently being written out
   logic [31:0] work_word;
   logic [14:0] work_off;
   logic [1:0]  byte_idx;
   logic [1:0]  next_idx;
   logic [3:0]  we_cnt;

   logic        done_req;

   logic [31:0] win_off;
   logic        in_win;
   logic        accept;
   logic        ovf_hit;
   logic        drain;

   // big-endian lane select: index 0 is the most significant byte
   function automatic logic [7:0] pick_byte(input logic [31:0] word,
                                            input logic [1:0]  idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

   assign win_off  = wr_addr - BASE_ADDR;
   assign in_win   = (win_off < WINDOW);
   assign accept   = wr_valid && in_win && !pend_valid && !rom_ready;
   assign ovf_hit  = wr_valid && in_win &&  pend_valid && !rom_ready;
   assign drain    = done_req && (state == S_IDLE) && !pend_valid;
   assign next_idx = byte_idx + 2'd1;
   assign wr_ready = !pend_valid;

   // state register; async reset also drops the write strobe immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // next-state, transfer decision and write-enable decode
   always_comb begin
      next_state = state;
      xfer       = 1'b0;
      rom_wr_en  = 1'b0;
      case (state)
         S_IDLE: begin
            if (pend_valid) begin
               xfer       = 1'b1;
               next_state = S_SETUP;
            end
         end
         S_SETUP: next_state = S_STROBE;
         S_STROBE: begin
            rom_wr_en = 1'b1;
            if (we_cnt == STROBE_LAST) next_state = S_HOLD;
         end
         S_HOLD: begin
            if (byte_idx != 2'd3) begin
               next_state = S_SETUP;
            end else if (pend_valid) begin
               xfer       = 1'b1;
               next_state = S_SETUP;
            end else begin
               next_state = S_IDLE;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   // pending slot: load on accept, empty on transfer, flag dropped words
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_valid <= 1'b0;
         pend_word  <= 32'd0;
         pend_off   <= 15'd0;
         overflow   <= 1'b0;
      end else begin
         if (accept) begin
            pend_valid <= 1'b1;
            pend_word  <= wr_data;
            pend_off   <= win_off[16:2];
         end else if (xfer) begin
            pend_valid <= 1'b0;
         end
         if (ovf_hit) overflow <= 1'b1;
      end
   end

   // work word, byte index and SRAM address/data; these change only on SETUP entry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         work_word <= 32'd0;
         work_off  <= 15'd0;
         byte_idx  <= 2'd0;
         rom_bank  <= 2'd0;
         rom_addr  <= 15'd0;
         rom_din   <= 8'd0;
      end else if (xfer) begin
         work_word              <= pend_word;
         work_off               <= pend_off;
         byte_idx               <= 2'd0;
         {rom_bank, rom_addr}   <= {pend_off, 2'd0};
         rom_din                <= pend_word[31:24];
      end else if ((state == S_HOLD) && (byte_idx != 2'd3)) begin
         byte_idx               <= next_idx;
         {rom_bank, rom_addr}   <= {work_off, next_idx};
         rom_din                <= pick_byte(work_word, next_idx);
      end
   end

   // strobe length counter, cleared whenever the strobe is not active
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  we_cnt <= 4'd0;
      else if (state == S_STROBE) we_cnt <= we_cnt + 4'd1;
      else                        we_cnt <= 4'd0;
   end

   // completed-byte counter, saturating at the full 128 KB
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         bytes_written <= 18'd0;
      else if ((state == S_HOLD) && (bytes_written != BYTES_MAX))
         bytes_written <= bytes_written + 18'd1;
   end

   // download-finished handshake: hand SRAM over once everything has drained
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done_req  <= 1'b0;
         rom_ready <= 1'b0;
         load_busy <= 1'b1;
      end else begin
         if (dl_done) done_req <= 1'b1;
         if (drain) begin
            rom_ready <= 1'b1;
            load_busy <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_loader
//  Purpose  : Self-checking bench for rom_loader: a word-level timing model
//             compared every cycle, plus directed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rom_loader;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int          WE   = 2;
   localparam int          P    = 2 + WE;   // cycles per byte
   localparam int          WL   = 4 * P;    // cycles per word

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_valid = 1'b0;
   logic [31:0] wr_addr  = 32'd0;
   logic [31:0] wr_data  = 32'd0;
   logic        wr_ready;
   logic        dl_done  = 1'b0;
   logic        rom_wr_en;
   logic [14:0] rom_addr;
   logic [1:0]  rom_bank;
   logic [7:0]  rom_din;
   logic        load_busy;
   logic        rom_ready;
   logic        overflow;
   logic [17:0] bytes_written;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   rom_loader #(.BASE_ADDR(BASE), .WE_CYCLES(WE)) dut (
      .clk(clk), .reset(reset),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(wr_ready), .dl_done(dl_done),
      .rom_wr_en(rom_wr_en), .rom_addr(rom_addr), .rom_bank(rom_bank),
      .rom_din(rom_din), .load_busy(load_busy), .rom_ready(rom_ready),
      .overflow(overflow), .bytes_written(bytes_written)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- word-level model ----------------
   // m_rem counts cycles left in the word being written (0 = idle)
   logic        m_pv, m_ovf, m_ready, m_busy, m_dreq;
   logic [31:0] m_pw, m_cw;
   logic [14:0] m_po, m_co;
   int          m_rem, m_bw;
   logic [1:0]  m_bank;
   logic [14:0] m_addr;
   logic [7:0]  m_din;

   always @(posedge clk or posedge reset) begin : model
      logic [31:0] off;
      logic        inwin, acc, ovf, xfer, drain, holdc;
      logic [16:0] ba;
      int          bi;
      if (reset) begin
         m_pv = 0; m_ovf = 0; m_ready = 0; m_busy = 1; m_dreq = 0;
         m_pw = 0; m_cw = 0; m_po = 0; m_co = 0; m_rem = 0; m_bw = 0;
         m_bank = 0; m_addr = 0; m_din = 0;
      end else begin
         off   = wr_addr - BASE;
         inwin = off < 32'h0002_0000;
         acc   = wr_valid && inwin && !m_pv && !m_ready;
         ovf   = wr_valid && inwin &&  m_pv && !m_ready;
         xfer  = m_pv && (m_rem <= 1);
         drain = m_dreq && (m_rem == 0) && !m_pv;
         holdc = (m_rem > 0) && (((WL - m_rem) % P) == P - 1);
         if (holdc && m_bw < 131072) m_bw = m_bw + 1;
         if (xfer) begin
            m_cw = m_pw; m_co = m_po; m_rem = WL; m_pv = 0;
         end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
         end
         if (acc) begin m_pv = 1; m_pw = wr_data; m_po = off[16:2]; end
         if (ovf) m_ovf = 1;
         if (dl_done) m_dreq = 1;
         if (drain) begin m_ready = 1; m_busy = 0; end
         if (m_rem > 0) begin
            bi     = (WL - m_rem) / P;
            ba     = {m_co, 2'(bi)};
            m_bank = ba[16:15];
            m_addr = ba[14:0];
            m_din  = 8'(m_cw >> (24 - 8 * bi));
         end
      end
   end

   // ---------------- strobe log ----------------
   logic [1:0]  lb [64];
   logic [14:0] la [64];
   logic [7:0]  ld [64];
   int          lt [64];
   int          log_n = 0;
   int          pw    = 0;
   logic        prev_en = 1'b0;

   // per-cycle comparison against the model, plus strobe capture and width check
   always @(negedge clk) begin : compare
      logic exp_en;
      exp_en = (m_rem > 0) && (((WL - m_rem) % P) >= 1) && (((WL - m_rem) % P) <= WE);
      checks = checks + 1;
      if ({rom_wr_en, rom_bank, rom_addr, rom_din, wr_ready, load_busy, rom_ready, overflow, bytes_written} !==
          {exp_en, m_bank, m_addr, m_din, !m_pv, m_busy, m_ready, m_ovf, 18'(m_bw)}) begin
         errors = errors + 1;
         $display("FAIL cycle t=%0t act en=%b bank=%0d addr=%h din=%h wrrdy=%b busy=%b romrdy=%b ovf=%b bw=%0d exp en=%b bank=%0d addr=%h din=%h wrrdy=%b busy=%b romrdy=%b ovf=%b bw=%0d",
                  $time, rom_wr_en, rom_bank, rom_addr, rom_din, wr_ready, load_busy, rom_ready, overflow, bytes_written,
                  exp_en, m_bank, m_addr, m_din, !m_pv, m_busy, m_ready, m_ovf, m_bw);
      end
      if (reset) begin
         pw = 0; prev_en = 1'b0;
      end else begin
         if (rom_wr_en) begin
            if (!prev_en && log_n < 64) begin
               lb[log_n] = rom_bank; la[log_n] = rom_addr;
               ld[log_n] = rom_din;  lt[log_n] = cyc;
               log_n = log_n + 1;
            end
            pw = pw + 1;
         end else if (prev_en) begin
            checks = checks + 1;
            if (pw != WE) begin
               errors = errors + 1;
               $display("FAIL strobe_width act=%0d exp=%0d", pw, WE);
            end
            pw = 0;
         end
         prev_en = rom_wr_en;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] d);
      wr_valid = 1'b1; wr_addr = a; wr_data = d;
      step(1);
      wr_valid = 1'b0;
   endtask

   task automatic chk_entry(input string name, input int i, input logic [1:0] b,
                            input logic [14:0] a, input logic [7:0] d);
      chk({name, "_bank"}, 32'(lb[i]), 32'(b));
      chk({name, "_addr"}, 32'(la[i]), 32'(a));
      chk({name, "_din"},  32'(ld[i]), 32'(d));
   endtask

   // ---------------- directed stimulus ----------------
   initial begin : stim
      int base;
      int n;
      reset = 1'b1;
      step(3);
      chk("reset_busy", 32'(load_busy), 32'd1);
      chk("reset_wr_ready", 32'(wr_ready), 32'd1);
      chk("reset_bw", 32'(bytes_written), 32'd0);
      reset = 1'b0;
      step(1);

      // single word
      send(32'h104, 32'hA1B2_C3D4);
      step(20);
      chk_entry("single0", 0, 2'd0, 15'h104, 8'hA1);
      chk_entry("single1", 1, 2'd0, 15'h105, 8'hB2);
      chk_entry("single2", 2, 2'd0, 15'h106, 8'hC3);
      chk_entry("single3", 3, 2'd0, 15'h107, 8'hD4);
      chk("single_bw", 32'(bytes_written), 32'd4);
      chk("single_pitch", 32'(lt[1] - lt[0]), 32'd4);

      // back-to-back words
      send(32'h1_FFFC, 32'h1122_3344);
      step(3);
      send(32'h0, 32'h5566_7788);
      step(40);
      chk_entry("btb_first", 4, 2'd3, 15'h7FFC, 8'h11);
      chk_entry("btb_last",  7, 2'd3, 15'h7FFF, 8'h44);
      chk_entry("btb_next",  8, 2'd0, 15'h0000, 8'h55);
      chk("btb_no_gap", 32'(lt[8] - lt[7]), 32'd4);
      chk("btb_ovf", 32'(overflow), 32'd0);
      chk("btb_bw", 32'(bytes_written), 32'd12);

      // out of window
      send(BASE + 32'h2_0000, 32'hFFFF_FFFF);
      chk("oow_wr_ready", 32'(wr_ready), 32'd1);
      step(10);
      chk("oow_no_write", 32'(log_n), 32'd12);
      chk("oow_ovf", 32'(overflow), 32'd0);

      // three words on consecutive cycles: the second meets a full slot
      wr_valid = 1'b1; wr_addr = 32'h200; wr_data = 32'h0102_0304; step(1);
      wr_addr = 32'h204; wr_data = 32'h0506_0708; step(1);
      wr_addr = 32'h208; wr_data = 32'h090A_0B0C; step(1);
      wr_valid = 1'b0;
      step(50);
      chk_entry("ovf_w1", 12, 2'd0, 15'h200, 8'h01);
      chk_entry("ovf_w3", 16, 2'd0, 15'h208, 8'h09);
      chk("ovf_w3_last", 32'(ld[19]), 32'h0C);
      chk("ovf_count", 32'(log_n), 32'd20);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_bw", 32'(bytes_written), 32'd20);

      // download done arrives during byte 1 with a second word pending
      send(32'h300, 32'hAABB_CCDD);
      step(2);
      send(32'h304, 32'hEEFF_0011);
      step(2);
      dl_done = 1'b1;
      step(1);
      dl_done = 1'b0;
      chk("done_not_early", 32'(rom_ready), 32'd0);
      n = 0;
      while (!rom_ready && n < 100) begin step(1); n++; end
      chk("done_timeout", 32'(rom_ready), 32'd1);
      chk("done_busy", 32'(load_busy), 32'd0);
      chk("done_bw", 32'(bytes_written), 32'd28);
      chk_entry("done_w1", 20, 2'd0, 15'h300, 8'hAA);
      chk_entry("done_w2", 27, 2'd0, 15'h307, 8'h11);
      send(32'h600, 32'h1234_5678);
      step(20);
      chk("after_done_ignored", 32'(log_n), 32'd28);
      chk("after_done_bw", 32'(bytes_written), 32'd28);

      // reset in the middle of a strobe
      reset = 1'b1; step(2); reset = 1'b0; step(1);
      send(32'h400, 32'hCAFE_F00D);
      n = 0;
      while (!rom_wr_en && n < 20) begin step(1); n++; end
      chk("rst_strobe_seen", 32'(rom_wr_en), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rst_we_async", 32'(rom_wr_en), 32'd0);
      chk("rst_busy", 32'(load_busy), 32'd1);
      chk("rst_ready", 32'(rom_ready), 32'd0);
      chk("rst_bw", 32'(bytes_written), 32'd0);
      chk("rst_addr", 32'({rom_bank, rom_addr, rom_din}), 32'd0);
      step(2);
      reset = 1'b0;
      step(1);
      base = log_n;
      send(32'h500, 32'hDEAD_BEEF);
      step(20);
      chk_entry("recover0", base,     2'd0, 15'h500, 8'hDE);
      chk_entry("recover3", base + 3, 2'd0, 15'h503, 8'hEF);
      chk("recover_bw", 32'(bytes_written), 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
